// File: rtl/jk_bank_counter_pkg.sv
// Shared definitions for the JK-cell bank counter: mode encoding and parameter legality.
package jk_bank_counter_pkg;

    localparam int JKB_WIDTH_MAX = 16;

    typedef enum logic [1:0] {
        JKB_MODE_JK   = 2'b00,
        JKB_MODE_UP   = 2'b01,
        JKB_MODE_DOWN = 2'b10,
        JKB_MODE_LOAD = 2'b11
    } jkb_mode_e;

    function automatic bit jkb_params_ok(input int width, input int modulus);
        return (width >= 1) && (width <= JKB_WIDTH_MAX) &&
               (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/jk_bank_counter_if.sv
// Control/status bundle of the JK bank counter; master drives controls, slave returns cell state.
interface jk_bank_counter_if #(parameter int WIDTH = 4);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic             tc;

    modport master (output en, mode, j, k, d, input q, q_n, tc);
    modport slave  (input en, mode, j, k, d, output q, q_n, tc);
endinterface

// File: rtl/jk_bank_counter_cell.sv
// Single JK flip-flop with asynchronous active-high reset; q_n is derived so it can never disagree.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_n
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign q_n = ~q;

endmodule

// File: rtl/jk_bank_counter.sv
// WIDTH-bit bank of JK cells usable as a raw JK register, mod-MODULUS up/down counter or load register.
module jk_bank_counter
    import jk_bank_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic clk,
    input  logic rst,
    jk_bank_counter_if.slave bus
);

    if (!jkb_params_ok(WIDTH, MODULUS)) begin : g_bad_params
        $error("jk_bank_counter: WIDTH must be 1..16 and MODULUS 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;
    jkb_mode_e        mode;

    assign mode = jkb_mode_e'(bus.mode);

    always_comb begin
        nxt   = q;
        j_drv = '0;
        k_drv = '0;
        if (bus.en) begin
            case (mode)
                JKB_MODE_JK: begin
                    j_drv = bus.j;
                    k_drv = bus.k;
                end
                JKB_MODE_UP:   nxt = (q >= CNT_MAX) ? '0 : q + ONE;
                JKB_MODE_DOWN: nxt = ((q == '0) || (q > CNT_MAX)) ? CNT_MAX : q - ONE;
                default:       nxt = (bus.d > CNT_MAX) ? CNT_MAX : bus.d;
            endcase
            // Arithmetic modes still move state through J/K: set rising bits, clear falling bits.
            if (mode != JKB_MODE_JK) begin
                j_drv = nxt & ~q;
                k_drv = ~nxt & q;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_drv[i]),
            .k   (k_drv[i]),
            .q   (q[i]),
            .q_n (q_n[i])
        );
    end

    assign bus.q   = q;
    assign bus.q_n = q_n;
    assign bus.tc  = bus.en & ~rst &
                     (((mode == JKB_MODE_UP) & (q >= CNT_MAX)) |
                      ((mode == JKB_MODE_DOWN) & (q == '0)));

endmodule

// File: tb/tb_jk_bank_counter.sv
// Directed-vector and randomised model check of jk_bank_counter at WIDTH=4, MODULUS=10.
module tb_jk_bank_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    jk_bank_counter_if #(.WIDTH(W)) bus ();

    jk_bank_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] d;
        logic       tc;
        logic [3:0] q;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [1:0] mode, input logic [3:0] j,
                       input logic [3:0] k, input logic [3:0] d, input logic tc, input logic [3:0] q);
        vec_t v;
        v.en = en; v.mode = mode; v.j = j; v.k = k; v.d = d; v.tc = tc; v.q = q;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic [1:0] mode, input logic [3:0] j,
                         input logic [3:0] k, input logic [3:0] d);
        bus.en = en; bus.mode = mode; bus.j = j; bus.k = k; bus.d = d;
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] q, input logic en, input logic [1:0] mode,
                                              input logic [3:0] j, input logic [3:0] k, input logic [3:0] d);
        int qi;
        qi = int'(q);
        if (!en) return q;
        case (mode)
            2'b00:   return (j & ~q) | (~k & q);
            2'b01:   return (qi >= MOD - 1) ? 4'd0 : 4'(qi + 1);
            2'b10:   return (qi == 0 || qi >= MOD) ? 4'(MOD - 1) : 4'(qi - 1);
            default: return (int'(d) < MOD) ? d : 4'(MOD - 1);
        endcase
    endfunction

    function automatic logic model_tc(input logic [3:0] q, input logic en, input logic [1:0] mode);
        return en && ((mode == 2'b01 && int'(q) >= MOD - 1) || (mode == 2'b10 && q == 4'd0));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] qm;
        logic [3:0] qn_exp;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0);

        // Directed table: tc is checked before the edge, q/q_n after it.
        add(1, 2'b00, 4'b1010, 4'b0000, 0, 0, 4'b1010);
        add(1, 2'b00, 4'b1111, 4'b1111, 0, 0, 4'b0101);
        add(1, 2'b00, 4'b0000, 4'b0100, 0, 0, 4'b0001);
        add(0, 2'b00, 4'b1111, 4'b1111, 0, 0, 4'b0001);
        add(1, 2'b11, 0, 0, 4'd0, 0, 4'd0);
        for (int i = 0; i < 12; i++)
            add(1, 2'b01, 0, 0, 0, ((i % 10) == 9), 4'((i + 1) % 10));
        add(1, 2'b11, 0, 0, 4'd5, 0, 4'd5);
        add(0, 2'b01, 0, 0, 0, 0, 4'd5);
        add(1, 2'b11, 0, 0, 4'd0, 0, 4'd0);
        add(1, 2'b10, 0, 0, 0, 1, 4'd9);
        add(1, 2'b10, 0, 0, 0, 0, 4'd8);
        add(1, 2'b10, 0, 0, 0, 0, 4'd7);
        add(1, 2'b00, 4'b1101, 4'b0010, 0, 0, 4'd13);
        add(1, 2'b10, 0, 0, 0, 0, 4'd9);
        add(1, 2'b00, 4'b0100, 4'b0000, 0, 0, 4'd13);
        add(1, 2'b01, 0, 0, 0, 1, 4'd0);
        add(1, 2'b11, 0, 0, 4'd6, 0, 4'd6);
        add(1, 2'b11, 0, 0, 4'd12, 0, 4'd9);
        add(1, 2'b00, 4'b0000, 4'b0000, 0, 0, 4'd9);
        add(1, 2'b01, 0, 0, 0, 1, 4'd0);
        add(0, 2'b11, 0, 0, 4'd3, 0, 4'd0);
        add(0, 2'b10, 0, 0, 0, 0, 4'd0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_q", int'(bus.q), 0);
        check("reset_qn", int'(bus.q_n), 15);
        check("reset_tc", int'(bus.tc), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].d);
            #1;
            check($sformatf("vec%0d_tc", i), int'(bus.tc), int'(vecs[i].tc));
            @(posedge clk);
            #1;
            qn_exp = ~vecs[i].q;
            check($sformatf("vec%0d_q", i), int'(bus.q), int'(vecs[i].q));
            check($sformatf("vec%0d_qn", i), int'(bus.q_n), int'(qn_exp));
        end

        // Async reset mid-cycle from q=7 while counting down.
        @(negedge clk);
        drive(1, 2'b11, 0, 0, 4'd7);
        @(posedge clk);
        #1;
        check("pre_rst_q", int'(bus.q), 7);
        drive(1, 2'b10, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q", int'(bus.q), 0);
        check("async_rst_qn", int'(bus.q_n), 15);
        check("async_rst_tc", int'(bus.tc), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_tc", int'(bus.tc), 1);
        @(posedge clk);
        #1;
        check("rst_release_q", int'(bus.q), 9);

        // Reset held across a toggle edge: no partial update.
        @(negedge clk);
        drive(1, 2'b00, 4'hF, 4'hF, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_toggle_q", int'(bus.q), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_toggle_q", int'(bus.q), 15);

        // Random phase against the behavioural model.
        qm = bus.q;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
                  4'($urandom), 4'($urandom));
            rst = ($urandom_range(0, 49) == 0);
            #1;
            if (rst) qm = 4'd0;
            check("rnd_tc", int'(bus.tc), rst ? 0 : int'(model_tc(qm, bus.en, bus.mode)));
            @(posedge clk);
            if (!rst) qm = model_next(qm, bus.en, bus.mode, bus.j, bus.k, bus.d);
            #1;
            qn_exp = ~qm;
            check("rnd_q", int'(bus.q), int'(qm));
            check("rnd_qn", int'(bus.q_n), int'(qn_exp));
        end
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
